i2f_scheduler: RTL and testbench

Shares a single 16-bit unsigned-integer-to-float32 converter between NREQ requesters using round-robin arbitration and valid/ready handshakes. Each conversion result is returned on one shared result channel, tagged with the id of the requester that issued it. The block sits between integer-producing front-end units and float consumers. It also keeps a running count of completed conversions for debug.

---
 rtl/i2f_pkg.sv | 13 +
 rtl/i2f_scheduler_if.sv | 24 ++
 rtl/i2f.sv | 23 ++
 rtl/i2f_scheduler_rr_arbiter.sv | 29 ++
 rtl/i2f_scheduler.sv | 89 ++++++++
 tb/tb_i2f_scheduler.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/i2f_pkg.sv
// Shared types and constants for the integer-to-float scheduler slice.
package i2f_pkg;
    localparam int INT_W = 16;
    localparam int FP_W = 32;
    localparam int FP32_BIAS = 127;
    localparam logic [31:0] FP32_ZERO = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/i2f_scheduler_if.sv
// Requester and result channel bundle for i2f_scheduler.
// master = requester/consumer side, slave = scheduler side.
interface i2f_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW = 2
);
    logic [NREQ-1:0]                 req_valid;
    logic [NREQ-1:0]                 req_ready;
    logic [NREQ*i2f_pkg::INT_W-1:0]  req_data;
    logic                            res_valid;
    logic                            res_ready;
    logic [i2f_pkg::FP_W-1:0]        res_data;
    logic [IDW-1:0]                  res_id;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/i2f.sv
// Exact 16-bit unsigned integer to IEEE-754 single conversion.
// Latency: combinational. Backpressure: none.
// Every 16-bit value fits in a 24-bit significand, so no rounding is needed.
module i2f
    import i2f_pkg::*;
(
    input  logic [INT_W-1:0] x,
    output logic [FP_W-1:0]  y
);
    logic [3:0]  p;
    logic [22:0] mant;

    always_comb begin
        p = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (x[i]) p = 4'(i);
        end
        // The leading one lands on bit 23 and falls off the 23-bit mantissa.
        mant = {7'b0, x} << (5'd23 - {1'b0, p});
        if (x == '0) y = FP32_ZERO;
        else         y = {1'b0, 8'(FP32_BIAS + int'(p)), mant};
    end
endmodule

// File: rtl/i2f_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter; search begins just after rr_ptr.
// Latency: combinational. Backpressure: none.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/i2f_scheduler.sv
// Shares one int16->fp32 converter among NREQ requesters with round-robin grants.
// Latency: accept at edge T, res_valid after edge T+1; one conversion per 3 cycles at best.
// Backpressure: res_ready low holds the result in DONE indefinitely; no grants meanwhile.
module i2f_scheduler
    import i2f_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    i2f_scheduler_if.slave  bus,
    output logic            busy,
    output logic [15:0]     conv_count
);
    state_t            state, nxt;
    logic [IDW-1:0]    rr_ptr;
    logic [INT_W-1:0]  op_r;
    logic [IDW-1:0]    id_r;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    gidx;
    logic              any;
    logic [FP_W-1:0]   conv_y;
    logic              hs;
    logic              xfer;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (gidx),
        .any    (any)
    );

    i2f u_i2f (
        .x (op_r),
        .y (conv_y)
    );

    assign hs   = (state == IDLE) && any;
    assign xfer = (state == DONE) && bus.res_valid && bus.res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (hs)   nxt = CONV;
            CONV:              nxt = DONE;
            DONE:    if (xfer) nxt = IDLE;
            default:           nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE) ? grant : '0;
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= IDW'(NREQ - 1);
            op_r          <= '0;
            id_r          <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= FP32_ZERO;
            bus.res_id    <= '0;
            conv_count    <= '0;
        end else begin
            if (hs) begin
                op_r   <= bus.req_data[int'(gidx)*INT_W +: INT_W];
                id_r   <= gidx;
                rr_ptr <= gidx;
            end
            if (state == CONV) begin
                bus.res_data  <= conv_y;
                bus.res_id    <= id_r;
                bus.res_valid <= 1'b1;
            end
            if (xfer) begin
                bus.res_valid <= 1'b0;
                conv_count    <= conv_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_i2f_scheduler.sv
// Directed bench for i2f_scheduler with hand-computed expected results.
module tb_i2f_scheduler;
    localparam int NREQ = 4;
    localparam int IDW = 2;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] conv_count;
    int          checks;
    int          failures;
    int          exp_cnt;
    int          last;
    int          e;

    logic [31:0] exp_tab [4];

    i2f_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    i2f_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .conv_count (conv_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", bus.res_data, 32'h0);
        chk("rst_res_id", 32'(bus.res_id), 32'd0);
        chk("rst_conv_count", 32'(conv_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction; starts and ends in IDLE just after a rising edge.
    task automatic do_req(input int idx, input logic [15:0] d, input logic [31:0] exp);
        bus.req_valid = '0;
        bus.req_valid[idx] = 1'b1;
        bus.req_data[idx*16 +: 16] = d;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("grant", 32'(bus.req_ready), 32'(1 << idx));
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        chk("conv_res_valid", 32'(bus.res_valid), 32'd0);
        chk("conv_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("res_valid", 32'(bus.res_valid), 32'd1);
        chk("res_data", bus.res_data, exp);
        chk("res_id", 32'(bus.res_id), 32'(idx));
        @(posedge clk);
        #1;
        exp_cnt++;
        @(negedge clk);
        chk("conv_count", 32'(conv_count), 32'(exp_cnt[15:0]));
        chk("idle_res_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        rst_n    = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        #2;
        do_reset();

        // Basic transaction and the distinctive encodings.
        do_req(0, 16'h0001, 32'h3F800000);
        do_req(2, 16'h0005, 32'h40A00000);
        do_req(2, 16'hFFFF, 32'h477FFF00);
        do_req(2, 16'h8000, 32'h47000000);
        do_req(2, 16'h0000, 32'h00000000);

        // All requesters contend: strict rotation from requester 0.
        do_reset();
        bus.req_data = {16'h0100, 16'h0003, 16'h0002, 16'h0001};
        exp_tab[0] = 32'h3F800000;
        exp_tab[1] = 32'h40000000;
        exp_tab[2] = 32'h40400000;
        exp_tab[3] = 32'h43800000;
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        last = NREQ - 1;
        for (int k = 0; k < 6; k++) begin
            e = (last + 1) % NREQ;
            @(negedge clk);
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << e));
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk("rr_res_data", bus.res_data, exp_tab[e]);
            chk("rr_res_id", 32'(bus.res_id), 32'(e));
            @(posedge clk);
            last = e;
            exp_cnt++;
        end
        #1 bus.req_valid = '0;
        @(negedge clk);
        chk("rr_conv_count", 32'(conv_count), 32'(exp_cnt));

        // Back-pressure stall on requester 1, then next grant goes to 2.
        do_reset();
        bus.res_ready = 1'b0;
        bus.req_data = {16'h0009, 16'h0005, 16'h0007, 16'h0001};
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("bp_grant", 32'(bus.req_ready), 32'h2);
        @(posedge clk);
        #1 bus.req_valid = '1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_res_data", bus.res_data, 32'h40E00000);
            chk("bp_res_id", 32'(bus.res_id), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_after_valid", 32'(bus.res_valid), 32'd0);
        chk("bp_after_count", 32'(conv_count), 32'd1);
        chk("bp_next_grant", 32'(bus.req_ready), 32'h4);

        // Reset while a result waits in DONE.
        bus.res_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("done_res_valid", 32'(bus.res_valid), 32'd1);
        chk("done_res_id", 32'(bus.res_id), 32'd2);
        chk("done_res_data", bus.res_data, 32'h40A00000);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_conv_count", 32'(conv_count), 32'd0);
        bus.req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_data", bus.res_data, 32'h3F800000);
        chk("post_rst_id", 32'(bus.res_id), 32'd0);
        @(posedge clk);
        #1;
        exp_cnt++;
        @(negedge clk);
        chk("post_rst_count", 32'(conv_count), 32'(exp_cnt));
        @(posedge clk);
        #1;

        // Counter wrap: preload near the top, then keep converting.
        force dut.conv_count = 16'hFFFE;
        #1;
        release dut.conv_count;
        exp_cnt = 32'hFFFE;
        do_req(3, 16'h1234, 32'h4591A000);
        do_req(1, 16'h00FF, 32'h437F0000);
        chk("wrap_zero", 32'(conv_count), 32'h0000);
        do_req(0, 16'h8000, 32'h47000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
